// File: rtl/video_timing_gen_pkg.sv
// Shared raster-timing types, the 720p60 timing set, and derived line/frame sizes.
package video_timing_gen_pkg;

    typedef logic signed [11:0] coord_t;

    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
    } video_timing_t;

    localparam video_timing_t VT_720P60 = '{
        h_active: 1280, h_fp: 110, h_sync: 40, h_bp: 220,
        v_active: 720,  v_fp: 5,   v_sync: 5,  v_bp: 20
    };

    function automatic int h_blank(input video_timing_t vt);
        return vt.h_fp + vt.h_sync + vt.h_bp;
    endfunction

    function automatic int h_total(input video_timing_t vt);
        return vt.h_active + h_blank(vt);
    endfunction

    function automatic int v_blank(input video_timing_t vt);
        return vt.v_fp + vt.v_sync + vt.v_bp;
    endfunction

    function automatic int v_total(input video_timing_t vt);
        return vt.v_active + v_blank(vt);
    endfunction

endpackage

// File: rtl/video_timing_gen_wrap_counter.sv
// Signed counter stepping MIN..MAX under enable, with a combinational next value and wrap pulse.
module video_timing_gen_wrap_counter
    import video_timing_gen_pkg::*;
#(
    parameter int MIN = 0,
    parameter int MAX = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic signed [11:0] next,
    output logic             wrap
);

    coord_t count;

    always_comb begin
        wrap = en && (count == coord_t'(MAX));
        next = count;
        if (wrap) begin
            next = coord_t'(MIN);
        end else if (en) begin
            next = count + coord_t'(1);
        end
    end

    // Parked on MAX so the first enabled cycle wraps straight into the frame start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= coord_t'(MAX);
        end else begin
            count <= next;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: signed coordinates, active flag, syncs and frame/line strobes,
// all registered from next-state counter values so every output describes the same pixel.
module video_timing_gen
    import video_timing_gen_pkg::*;
#(
    parameter int H_ACTIVE = VT_720P60.h_active,
    parameter int H_FP     = VT_720P60.h_fp,
    parameter int H_SYNC   = VT_720P60.h_sync,
    parameter int H_BP     = VT_720P60.h_bp,
    parameter int V_ACTIVE = VT_720P60.v_active,
    parameter int V_FP     = VT_720P60.v_fp,
    parameter int V_SYNC   = VT_720P60.v_sync,
    parameter int V_BP     = VT_720P60.v_bp,
    parameter bit SYNC_POS = 1'b1
) (
    input  logic               pixel_clk,
    input  logic               rst,
    input  logic               en,
    output logic signed [11:0] hpos,
    output logic signed [11:0] vpos,
    output logic               active,
    output logic               hsync,
    output logic               vsync,
    output logic               fsync,
    output logic               lsync,
    output logic [15:0]        frame_cnt
);

    localparam video_timing_t VT = '{
        h_active: H_ACTIVE, h_fp: H_FP, h_sync: H_SYNC, h_bp: H_BP,
        v_active: V_ACTIVE, v_fp: V_FP, v_sync: V_SYNC, v_bp: V_BP
    };
    localparam int H_BLANK_C = h_blank(VT);
    localparam int H_TOTAL_C = h_total(VT);
    localparam int V_BLANK_C = v_blank(VT);
    localparam int V_TOTAL_C = v_total(VT);

    localparam coord_t H_MIN   = coord_t'(-H_BLANK_C);
    localparam coord_t V_MIN   = coord_t'(-V_BLANK_C);
    localparam coord_t HS_LO   = coord_t'(-H_BLANK_C + H_FP);
    localparam coord_t HS_HI   = coord_t'(-H_BLANK_C + H_FP + H_SYNC - 1);
    localparam coord_t VS_LO   = coord_t'(-V_BLANK_C + V_FP);
    localparam coord_t VS_HI   = coord_t'(-V_BLANK_C + V_FP + V_SYNC - 1);
    localparam bit     SYNC_OFF = ~SYNC_POS;

    if (H_TOTAL_C > 2047) begin : g_h_total_chk
        $error("H_TOTAL exceeds the signed 12-bit coordinate range");
    end
    if (V_TOTAL_C > 2047) begin : g_v_total_chk
        $error("V_TOTAL exceeds the signed 12-bit coordinate range");
    end

    coord_t h_next;
    coord_t v_next;
    logic   h_wrap;
    logic   v_wrap;
    logic   frame_start;
    logic   active_n;
    logic   hs_win;
    logic   vs_win;

    video_timing_gen_wrap_counter #(
        .MIN(-H_BLANK_C),
        .MAX(H_ACTIVE - 1)
    ) u_hcnt (
        .clk (pixel_clk),
        .rst (rst),
        .en  (en),
        .next(h_next),
        .wrap(h_wrap)
    );

    video_timing_gen_wrap_counter #(
        .MIN(-V_BLANK_C),
        .MAX(V_ACTIVE - 1)
    ) u_vcnt (
        .clk (pixel_clk),
        .rst (rst),
        .en  (h_wrap),
        .next(v_next),
        .wrap(v_wrap)
    );

    always_comb begin
        frame_start = h_wrap && v_wrap;
        active_n    = !h_next[11] && !v_next[11];
        hs_win      = (h_next >= HS_LO) && (h_next <= HS_HI);
        vs_win      = (v_next >= VS_LO) && (v_next <= VS_HI);
    end

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            hpos      <= H_MIN;
            vpos      <= V_MIN;
            active    <= 1'b0;
            hsync     <= SYNC_OFF;
            vsync     <= SYNC_OFF;
            fsync     <= 1'b0;
            lsync     <= 1'b0;
            frame_cnt <= '0;
        end else if (en) begin
            hpos      <= h_next;
            vpos      <= v_next;
            active    <= active_n;
            hsync     <= hs_win ? SYNC_POS : SYNC_OFF;
            vsync     <= vs_win ? SYNC_POS : SYNC_OFF;
            fsync     <= frame_start;
            lsync     <= h_wrap;
            frame_cnt <= frame_cnt + 16'(frame_start);
        end else begin
            fsync     <= 1'b0;
            lsync     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a reduced raster, with an inverted-sync twin instance.
module tb_video_timing_gen;

    localparam int HA  = 8;
    localparam int HFP = 2;
    localparam int HSW = 3;
    localparam int HBP = 4;
    localparam int VA  = 6;
    localparam int VFP = 1;
    localparam int VSW = 2;
    localparam int VBP = 3;
    localparam int HB  = 9;     // 2+3+4
    localparam int VB  = 6;     // 1+2+3
    localparam int FRAME = 204; // 17 * 12
    localparam int HS_LO = -7, HS_HI = -5;
    localparam int VS_LO = -5, VS_HI = -4;

    typedef struct {
        int          h;
        int          v;
        logic        act;
        logic        hs;
        logic        vs;
        logic        fs;
        logic        ls;
        logic [15:0] fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic signed [11:0] hpos, vpos, hpos_b, vpos_b;
    logic active, hsync, vsync, fsync, lsync;
    logic active_b, hsync_b, vsync_b, fsync_b, lsync_b;
    logic [15:0] frame_cnt, frame_cnt_b;

    exp_t q[$];
    exp_t cur;
    logic m_pre;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .SYNC_POS(1'b1)
    ) dut (
        .pixel_clk(clk), .rst(rst), .en(en),
        .hpos(hpos), .vpos(vpos), .active(active),
        .hsync(hsync), .vsync(vsync), .fsync(fsync), .lsync(lsync),
        .frame_cnt(frame_cnt)
    );

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .SYNC_POS(1'b0)
    ) dut_b (
        .pixel_clk(clk), .rst(rst), .en(en),
        .hpos(hpos_b), .vpos(vpos_b), .active(active_b),
        .hsync(hsync_b), .vsync(vsync_b), .fsync(fsync_b), .lsync(lsync_b),
        .frame_cnt(frame_cnt_b)
    );

    task automatic check(input string name, input int act, input int req);
        n_chk++;
        if (act == req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic void model_reset();
        m_pre   = 1'b1;
        cur.h   = -HB;
        cur.v   = -VB;
        cur.act = 1'b0;
        cur.hs  = 1'b0;
        cur.vs  = 1'b0;
        cur.fs  = 1'b0;
        cur.ls  = 1'b0;
        cur.fc  = '0;
    endfunction

    function automatic void model_step(input logic e);
        if (!e) begin
            cur.fs = 1'b0;
            cur.ls = 1'b0;
            return;
        end
        if (m_pre) begin
            m_pre = 1'b0;
            cur.h = -HB;
            cur.v = -VB;
        end else begin
            cur.h++;
            if (cur.h == HA) begin
                cur.h = -HB;
                cur.v++;
                if (cur.v == VA) cur.v = -VB;
            end
        end
        cur.act = (cur.h >= 0) && (cur.v >= 0);
        cur.hs  = (cur.h >= HS_LO) && (cur.h <= HS_HI);
        cur.vs  = (cur.v >= VS_LO) && (cur.v <= VS_HI);
        cur.ls  = (cur.h == -HB);
        cur.fs  = cur.ls && (cur.v == -VB);
        if (cur.fs) cur.fc++;
    endfunction

    task automatic step(input logic e);
        @(negedge clk);
        en = e;
        model_step(e);
        q.push_back(cur);
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_hpos"}, int'(hpos), -HB);
        check({tag, "_vpos"}, int'(vpos), -VB);
        check({tag, "_active"}, int'(active), 0);
        check({tag, "_hsync"}, int'(hsync), 0);
        check({tag, "_vsync"}, int'(vsync), 0);
        check({tag, "_hsync_b"}, int'(hsync_b), 1);
        check({tag, "_vsync_b"}, int'(vsync_b), 1);
        check({tag, "_fsync"}, int'(fsync), 0);
        check({tag, "_lsync"}, int'(lsync), 0);
        check({tag, "_frame_cnt"}, int'(frame_cnt), 0);
    endtask

    task automatic check_frame_start(input string tag, input int fc);
        check({tag, "_hpos"}, int'(hpos), -HB);
        check({tag, "_vpos"}, int'(vpos), -VB);
        check({tag, "_fsync"}, int'(fsync), 1);
        check({tag, "_lsync"}, int'(lsync), 1);
        check({tag, "_frame_cnt"}, int'(frame_cnt), fc);
    endtask

    // Monitor: every clocked cycle with a pending expectation is compared on both instances.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("sb_hpos", int'(hpos), e.h);
            check("sb_vpos", int'(vpos), e.v);
            check("sb_active", int'(active), int'(e.act));
            check("sb_hsync", int'(hsync), int'(e.hs));
            check("sb_vsync", int'(vsync), int'(e.vs));
            check("sb_fsync", int'(fsync), int'(e.fs));
            check("sb_lsync", int'(lsync), int'(e.ls));
            check("sb_frame_cnt", int'(frame_cnt), int'(e.fc));
            check("sb_b_hpos", int'(hpos_b), e.h);
            check("sb_b_vpos", int'(vpos_b), e.v);
            check("sb_b_active", int'(active_b), int'(e.act));
            check("sb_b_hsync", int'(hsync_b), int'(!e.hs));
            check("sb_b_vsync", int'(vsync_b), int'(!e.vs));
            check("sb_b_fsync", int'(fsync_b), int'(e.fs));
            check("sb_b_lsync", int'(lsync_b), int'(e.ls));
            check("sb_b_frame_cnt", int'(frame_cnt_b), int'(e.fc));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got t=%0t, expected below 200000", $time);
        $fatal(1);
    end

    initial begin
        int hs_cyc, act_cyc, fs_n, ls_n, vs_lines, act_lines, cnt;
        rst = 1'b0;
        en  = 1'b0;
        model_reset();
        #1 rst = 1'b1;
        #1 check_reset("por");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0);
        step(1'b1);
        check_frame_start("first", 1);

        hs_cyc = 0; act_cyc = 0; fs_n = 1; ls_n = 1; vs_lines = 0; act_lines = 0;
        repeat (FRAME - 1) begin
            step(1'b1);
            if (hsync) hs_cyc++;
            if (active) act_cyc++;
            if (fsync) fs_n++;
            if (lsync) begin
                ls_n++;
                if (vsync) vs_lines++;
                if (vpos >= 0) act_lines++;
            end
        end
        check("frame_hsync_cycles", hs_cyc, 36);
        check("frame_active_cycles", act_cyc, 48);
        check("frame_fsync_pulses", fs_n, 1);
        check("frame_lsync_pulses", ls_n, 12);
        check("frame_vsync_lines", vs_lines, 2);
        check("frame_active_lines", act_lines, 6);
        check("last_hpos", int'(hpos), HA - 1);
        check("last_vpos", int'(vpos), VA - 1);
        step(1'b1);
        check_frame_start("second", 2);

        for (int i = 0; i < FRAME && !(cur.h == 3 && cur.v == 2); i++) step(1'b1);
        check("pause_at_hpos", int'(hpos), 3);
        check("pause_at_vpos", int'(vpos), 2);
        repeat (10) step(1'b0);
        check("paused_hpos", int'(hpos), 3);
        check("paused_vpos", int'(vpos), 2);
        check("paused_active", int'(active), 1);
        cnt = 10;
        step(1'b1);
        cnt++;
        check("resume_hpos", int'(hpos), 4);
        while (!fsync && cnt < 1000) begin
            step(1'b1);
            cnt++;
        end
        check("pause_period", cnt, 66);
        check("third_frame_cnt", int'(frame_cnt), 3);

        repeat (3) step(1'b0);
        check("strobe_pause_fsync", int'(fsync), 0);
        check("strobe_pause_lsync", int'(lsync), 0);
        check("strobe_pause_hpos", int'(hpos), -HB);
        check("strobe_pause_frame_cnt", int'(frame_cnt), 3);
        step(1'b1);
        check("strobe_resume_hpos", int'(hpos), -HB + 1);

        for (int i = 0; i < FRAME && !(cur.h == 0 && cur.v == 4); i++) step(1'b1);
        check("mid_vpos", int'(vpos), 4);
        #1 rst = 1'b1;
        en = 1'b0;
        model_reset();
        #1 check_reset("mid");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0);
        step(1'b1);
        check_frame_start("restart", 1);
        repeat (FRAME - 1) step(1'b1);
        step(1'b1);
        check_frame_start("restart_next", 2);

        #20;
        check("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
